input_unit: RTL and testbench

INPUT_UNIT -- requirements
Module: input_unit

---
 rtl/input_unit.sv | 135 +++++++++++++
 tb/tb_input_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_unit.sv
// Signed decimal entry unit: collects up to three BCD digits plus a sign, then
// converts them serially into an 8-bit two's-complement VALUE with range check.
module input_unit (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_digit,
  input  logic       i_digit_stb,
  input  logic       i_neg_stb,
  input  logic       i_enter_stb,
  input  logic       i_clr_stb,
  output logic [7:0] o_value,
  output logic       o_valid,
  output logic       o_err,
  output logic       o_neg,
  output logic [1:0] o_dig_cnt,
  output logic       o_busy,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_ENTRY   = 2'd1,
    S_CONVERT = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [11:0] r_digits, w_digits_nxt;
  logic [1:0]  r_cnt, w_cnt_nxt;
  logic        r_neg, w_neg_nxt;
  logic        r_err, w_err_nxt;
  logic [9:0]  r_acc, w_acc_nxt;
  logic [1:0]  r_step, w_step_nxt;
  logic [7:0]  r_value, w_value_nxt;
  logic        r_valid, w_valid_nxt;

  logic [9:0]  w_acc_x10;
  logic        w_in_range;

  // Digits are consumed from the top nibble while the register shifts left,
  // so D2, D1, D0 arrive in order on successive convert edges.
  assign w_acc_x10  = (r_acc << 3) + (r_acc << 1) + {6'd0, r_digits[11:8]};
  assign w_in_range = r_neg ? (r_acc <= 10'd128) : (r_acc <= 10'd127);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= S_EMPTY;
      r_digits <= 12'd0;
      r_cnt    <= 2'd0;
      r_neg    <= 1'b0;
      r_err    <= 1'b0;
      r_acc    <= 10'd0;
      r_step   <= 2'd0;
      r_value  <= 8'd0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_digits <= w_digits_nxt;
      r_cnt    <= w_cnt_nxt;
      r_neg    <= w_neg_nxt;
      r_err    <= w_err_nxt;
      r_acc    <= w_acc_nxt;
      r_step   <= w_step_nxt;
      r_value  <= w_value_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_digits_nxt = r_digits;
    w_cnt_nxt    = r_cnt;
    w_neg_nxt    = r_neg;
    w_err_nxt    = r_err;
    w_acc_nxt    = r_acc;
    w_step_nxt   = r_step;
    w_value_nxt  = r_value;
    w_valid_nxt  = 1'b0;

    if (i_clr_stb) begin
      w_state_nxt  = S_EMPTY;
      w_digits_nxt = 12'd0;
      w_cnt_nxt    = 2'd0;
      w_neg_nxt    = 1'b0;
      w_err_nxt    = 1'b0;
      w_acc_nxt    = 10'd0;
      w_step_nxt   = 2'd0;
    end else begin
      case (r_state)
        S_EMPTY, S_ENTRY: begin
          if (i_enter_stb) begin
            w_state_nxt = S_CONVERT;
            w_acc_nxt   = 10'd0;
            w_step_nxt  = 2'd0;
            w_err_nxt   = 1'b0;
          end else if (i_neg_stb) begin
            w_neg_nxt = ~r_neg;
          end else if (i_digit_stb && (i_digit <= 4'd9) && (r_cnt != 2'd3)) begin
            w_digits_nxt = {r_digits[7:0], i_digit};
            w_cnt_nxt    = r_cnt + 2'd1;
            w_state_nxt  = S_ENTRY;
          end
        end
        S_CONVERT: begin
          if (r_step != 2'd3) begin
            w_acc_nxt    = w_acc_x10;
            w_digits_nxt = {r_digits[7:0], 4'd0};
            w_step_nxt   = r_step + 2'd1;
          end else begin
            if (w_in_range) begin
              w_value_nxt = r_neg ? (~r_acc[7:0] + 8'd1) : r_acc[7:0];
              w_valid_nxt = 1'b1;
            end else begin
              w_err_nxt = 1'b1;
            end
            w_digits_nxt = 12'd0;
            w_cnt_nxt    = 2'd0;
            w_neg_nxt    = 1'b0;
            w_step_nxt   = 2'd0;
            w_state_nxt  = S_EMPTY;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  assign o_value   = r_value;
  assign o_valid   = r_valid;
  assign o_err     = r_err;
  assign o_neg     = r_neg;
  assign o_dig_cnt = r_cnt;
  assign o_busy    = (r_state == S_CONVERT);
  assign o_state   = r_state;

endmodule

// File: tb/tb_input_unit.sv
// Directed bench for input_unit: entry, sign, range check, strobe priority,
// fixed conversion latency and asynchronous reset abort.
module tb_input_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] i_digit;
  logic       i_digit_stb, i_neg_stb, i_enter_stb, i_clr_stb;
  logic [7:0] o_value;
  logic       o_valid, o_err, o_neg, o_busy;
  logic [1:0] o_dig_cnt, o_state;

  int total = 0;
  int bad   = 0;

  input_unit dut (
    .i_clk(clk), .i_reset(rst),
    .i_digit(i_digit), .i_digit_stb(i_digit_stb), .i_neg_stb(i_neg_stb),
    .i_enter_stb(i_enter_stb), .i_clr_stb(i_clr_stb),
    .o_value(o_value), .o_valid(o_valid), .o_err(o_err), .o_neg(o_neg),
    .o_dig_cnt(o_dig_cnt), .o_busy(o_busy), .o_state(o_state)
  );

  always #5 clk = ~clk;

  task automatic pulse_digit(input logic [3:0] d);
    @(negedge clk); i_digit = d; i_digit_stb = 1'b1;
    @(negedge clk); i_digit_stb = 1'b0;
  endtask

  task automatic pulse_neg();
    @(negedge clk); i_neg_stb = 1'b1;
    @(negedge clk); i_neg_stb = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); i_clr_stb = 1'b1;
    @(negedge clk); i_clr_stb = 1'b0;
  endtask

  // Enter then check VALID appears exactly 4 edges after the sampling edge.
  task automatic run_enter(input string name, input logic exp_valid,
                           input logic [7:0] exp_value, input logic exp_err);
    @(negedge clk); i_enter_stb = 1'b1;
    @(negedge clk); i_enter_stb = 1'b0;
    total++;
    if (o_busy !== 1'b1 || o_err !== 1'b0) begin
      bad++; $display("FAIL %s_start busy=%b err=%b want busy=1 err=0", name, o_busy, o_err);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k < 4) begin
        total++;
        if (o_valid !== 1'b0 || o_busy !== 1'b1) begin
          bad++; $display("FAIL %s_lat%0d valid=%b busy=%b want 0/1", name, k, o_valid, o_busy);
        end
      end
    end
    total++;
    if (o_valid !== exp_valid || o_value !== exp_value || o_err !== exp_err) begin
      bad++;
      $display("FAIL %s_result valid=%b value=%h err=%b want valid=%b value=%h err=%b",
               name, o_valid, o_value, o_err, exp_valid, exp_value, exp_err);
    end
    total++;
    if (o_dig_cnt !== 2'd0 || o_neg !== 1'b0 || o_busy !== 1'b0) begin
      bad++; $display("FAIL %s_after cnt=%0d neg=%b busy=%b want 0/0/0", name, o_dig_cnt, o_neg, o_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_digit = 4'd0;
    i_digit_stb = 0; i_neg_stb = 0; i_enter_stb = 0; i_clr_stb = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (o_value !== 8'h00 || o_valid !== 0 || o_err !== 0 || o_neg !== 0 ||
        o_dig_cnt !== 2'd0 || o_busy !== 0 || o_state !== 2'd0) begin
      bad++;
      $display("FAIL reset value=%h valid=%b err=%b neg=%b cnt=%0d busy=%b state=%0d want all 0",
               o_value, o_valid, o_err, o_neg, o_dig_cnt, o_busy, o_state);
    end
  endtask

  task automatic test_positive_max();
    pulse_digit(4'd1);
    total++;
    if (o_state !== 2'd1 || o_dig_cnt !== 2'd1) begin
      bad++; $display("FAIL first_digit state=%0d cnt=%0d want 1/1", o_state, o_dig_cnt);
    end
    pulse_digit(4'd2); pulse_digit(4'd7);
    total++;
    if (o_dig_cnt !== 2'd3) begin
      bad++; $display("FAIL cnt_127 cnt=%0d want 3", o_dig_cnt);
    end
    run_enter("pos127", 1'b1, 8'h7F, 1'b0);
  endtask

  task automatic test_overflow();
    pulse_digit(4'd1); pulse_digit(4'd2); pulse_digit(4'd8);
    run_enter("pos128", 1'b0, 8'h7F, 1'b1);
    repeat (3) @(negedge clk);
    total++;
    if (o_err !== 1'b1) begin
      bad++; $display("FAIL err_sticky err=%b want 1", o_err);
    end
    pulse_clr();
    total++;
    if (o_err !== 1'b0 || o_value !== 8'h7F || o_valid !== 1'b0) begin
      bad++; $display("FAIL clr_err err=%b value=%h valid=%b want 0/7f/0", o_err, o_value, o_valid);
    end
  endtask

  task automatic test_negative();
    pulse_neg();
    total++;
    if (o_neg !== 1'b1) begin
      bad++; $display("FAIL neg_toggle neg=%b want 1", o_neg);
    end
    pulse_digit(4'd1); pulse_digit(4'd2); pulse_digit(4'd8);
    run_enter("neg128", 1'b1, 8'h80, 1'b0);
    pulse_neg(); pulse_digit(4'd5);
    run_enter("neg5", 1'b1, 8'hFB, 1'b0);
  endtask

  task automatic test_digit_limits();
    pulse_digit(4'hC);
    total++;
    if (o_dig_cnt !== 2'd0 || o_state !== 2'd0) begin
      bad++; $display("FAIL bad_digit cnt=%0d state=%0d want 0/0", o_dig_cnt, o_state);
    end
    pulse_digit(4'd4); pulse_digit(4'd5); pulse_digit(4'd6); pulse_digit(4'd7);
    total++;
    if (o_dig_cnt !== 2'd3) begin
      bad++; $display("FAIL cnt_full cnt=%0d want 3", o_dig_cnt);
    end
    run_enter("big456", 1'b0, 8'hFB, 1'b1);
  endtask

  task automatic test_neg_zero();
    pulse_neg();
    run_enter("negzero", 1'b1, 8'h00, 1'b0);
  endtask

  task automatic test_clr_enter();
    pulse_digit(4'd3);
    @(negedge clk); i_clr_stb = 1'b1; i_enter_stb = 1'b1;
    @(negedge clk); i_clr_stb = 1'b0; i_enter_stb = 1'b0;
    total++;
    if (o_busy !== 1'b0 || o_dig_cnt !== 2'd0 || o_state !== 2'd0) begin
      bad++; $display("FAIL clr_enter busy=%b cnt=%0d state=%0d want 0/0/0", o_busy, o_dig_cnt, o_state);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (o_valid !== 1'b0 || o_value !== 8'h00) begin
        bad++; $display("FAIL clr_enter_quiet%0d valid=%b value=%h want 0/00", k, o_valid, o_value);
      end
    end
  endtask

  task automatic test_neg_busy();
    pulse_digit(4'd9);
    @(negedge clk); i_enter_stb = 1'b1;
    @(negedge clk); i_enter_stb = 1'b0; i_neg_stb = 1'b1;
    @(negedge clk); i_neg_stb = 1'b0;
    total++;
    if (o_neg !== 1'b0 || o_busy !== 1'b1) begin
      bad++; $display("FAIL neg_busy neg=%b busy=%b want 0/1", o_neg, o_busy);
    end
    repeat (3) @(negedge clk);
    total++;
    if (o_valid !== 1'b1 || o_value !== 8'h09) begin
      bad++; $display("FAIL neg_busy_result valid=%b value=%h want 1/09", o_valid, o_value);
    end
  endtask

  task automatic test_back_to_back();
    pulse_digit(4'd4); pulse_digit(4'd2);
    run_enter("b2b_first", 1'b1, 8'h2A, 1'b0);
    i_digit = 4'd3; i_digit_stb = 1'b1;
    @(negedge clk); i_digit_stb = 1'b0;
    total++;
    if (o_dig_cnt !== 2'd1 || o_state !== 2'd1 || o_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_entry cnt=%0d state=%0d valid=%b want 1/1/0", o_dig_cnt, o_state, o_valid);
    end
    pulse_neg();
    run_enter("b2b_second", 1'b1, 8'hFD, 1'b0);
  endtask

  task automatic test_reset_mid();
    pulse_digit(4'd9); pulse_digit(4'd9);
    @(negedge clk); i_enter_stb = 1'b1;
    @(negedge clk); i_enter_stb = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (o_value !== 8'h00 || o_valid !== 0 || o_err !== 0 || o_neg !== 0 ||
        o_dig_cnt !== 2'd0 || o_busy !== 0) begin
      bad++;
      $display("FAIL reset_mid value=%h valid=%b err=%b neg=%b cnt=%0d busy=%b want all 0",
               o_value, o_valid, o_err, o_neg, o_dig_cnt, o_busy);
    end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++;
      if (o_valid !== 1'b0 || o_value !== 8'h00 || o_busy !== 1'b0) begin
        bad++; $display("FAIL reset_mid_after%0d valid=%b value=%h busy=%b want 0/00/0",
                        k, o_valid, o_value, o_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_positive_max();
    test_overflow();
    test_negative();
    test_digit_limits();
    test_neg_zero();
    test_clr_enter();
    test_neg_busy();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
